// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-decode stage.
//   imm_fmt_t      : immediate format classes (R/I/S/B/U/J/Z)
//   stage_state_t  : occupancy of the output register / skid buffer
//   OPC_*          : RV base opcode constants (inst[6:0])
//   imm_*_raw      : raw immediate fields, already bit-shuffled but not widened;
//                    widening to XLEN happens where XLEN is known.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    function automatic logic [11:0] imm_i_raw(input logic [31:0] inst);
        return inst[31:20];
    endfunction

    function automatic logic [11:0] imm_s_raw(input logic [31:0] inst);
        return {inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [12:0] imm_b_raw(input logic [31:0] inst);
        return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u_raw(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

    function automatic logic [20:0] imm_j_raw(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // CSR immediate form: uimm[4:0] (rs1 field) above the 12-bit CSR address.
    function automatic logic [16:0] imm_z_raw(input logic [31:0] inst);
        return {inst[19:15], inst[31:20]};
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
//   inst_i    [31:0]     raw instruction word
//   fmt_o     imm_fmt_t  immediate format
//   imm_o     [XLEN-1:0] sign/zero-extended immediate (0 for R)
//   illegal_o            opcode not in the supported set
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output imm_fmt_t        fmt_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    imm_fmt_t        fmt_s;
    logic            illegal_s;
    logic [XLEN-1:0] imm_s;

    // Opcode classification; the *32 opcodes only exist on RV64.
    always_comb begin
        fmt_s     = FMT_R;
        illegal_s = 1'b0;
        case (inst_i[6:0])
            OPC_LUI, OPC_AUIPC: fmt_s = FMT_U;
            OPC_JAL:            fmt_s = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE: fmt_s = FMT_I;
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    fmt_s = FMT_I;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_STORE:  fmt_s = FMT_S;
            OPC_BRANCH: fmt_s = FMT_B;
            // funct3[2] separates the CSR-immediate forms from the rest of SYSTEM
            OPC_SYSTEM: begin
                if (inst_i[14]) begin
                    fmt_s = FMT_Z;
                end else begin
                    fmt_s = FMT_I;
                end
            end
            OPC_OP: fmt_s = FMT_R;
            OPC_OP32: begin
                if (XLEN == 64) begin
                    fmt_s = FMT_R;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Widen the selected raw field; only Z is zero-extended.
    always_comb begin
        imm_s = '0;
        case (fmt_s)
            FMT_I:   imm_s = XLEN'($signed(imm_i_raw(inst_i)));
            FMT_S:   imm_s = XLEN'($signed(imm_s_raw(inst_i)));
            FMT_B:   imm_s = XLEN'($signed(imm_b_raw(inst_i)));
            FMT_U:   imm_s = XLEN'($signed(imm_u_raw(inst_i)));
            FMT_J:   imm_s = XLEN'($signed(imm_j_raw(inst_i)));
            FMT_Z:   imm_s = XLEN'(imm_z_raw(inst_i));
            default: imm_s = '0;
        endcase
    end

    assign fmt_o     = fmt_s;
    assign imm_o     = imm_s;
    assign illegal_o = illegal_s;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage (fetch -> register read).
//   clk, reset                 clock; asynchronous active-high reset
//   flush                      synchronous discard of all held entries
//   in_valid/in_ready          upstream handshake
//   in_inst [31:0], in_pc      incoming instruction and its address
//   out_valid/out_ready        downstream handshake
//   out_inst, out_pc           passthrough of the held entry
//   out_fmt [2:0]              imm_fmt_t of the held entry
//   out_imm, out_target        extended immediate and out_pc + out_imm
//   out_illegal                unsupported opcode
// SKID=1 adds a second entry so in_ready can be registered at full throughput;
// SKID=0 uses a single entry with combinational in_ready.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        imm_fmt_t        fmt;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    imm_fmt_t        ext_fmt_s;
    logic [XLEN-1:0] ext_imm_s;
    logic            ext_illegal_s;
    entry_t          in_entry_s;

    entry_t          out_q, out_d;
    entry_t          skid_q, skid_d;
    stage_state_t    state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            in_ready_s;
    logic            accept_s;
    logic            xfer_s;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst_i    (in_inst),
        .fmt_o     (ext_fmt_s),
        .imm_o     (ext_imm_s),
        .illegal_o (ext_illegal_s)
    );

    // Assemble the decoded entry, including the wrapping target add.
    always_comb begin
        in_entry_s         = '0;
        in_entry_s.inst    = in_inst;
        in_entry_s.pc      = in_pc;
        in_entry_s.fmt     = ext_fmt_s;
        in_entry_s.imm     = ext_imm_s;
        in_entry_s.target  = in_pc + ext_imm_s;
        in_entry_s.illegal = ext_illegal_s;
    end

    // Without the skid entry, a full stage can only accept when it also drains.
    assign in_ready_s = (SKID != 0) ? in_ready_q
                                    : ((state_q == ST_EMPTY) || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign xfer_s     = (state_q != ST_EMPTY) && out_ready;

    // Occupancy next-state and entry movement; flush overrides any accept.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        out_d   = in_entry_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && xfer_s) begin
                        out_d = in_entry_s;
                    end else if (accept_s) begin
                        state_d = ST_TWO;
                        skid_d  = in_entry_s;
                    end else if (xfer_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the skid entry can move
                    if (xfer_s) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    // State and data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_inst    = out_q.inst;
    assign out_pc      = out_q.pc;
    assign out_fmt     = out_q.fmt;
    assign out_imm     = out_q.imm;
    assign out_target  = out_q.target;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // DUT A: XLEN=32, SKID=1
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_inst, a_in_pc, a_out_inst, a_out_pc, a_out_imm, a_out_target;
    logic [2:0]  a_out_fmt;

    // DUT B: XLEN=64, SKID=0
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_inst, b_out_inst;
    logic [63:0] b_in_pc, b_out_pc, b_out_imm, b_out_target;
    logic [2:0]  b_out_fmt;

    int n_tests = 0;
    int n_fail  = 0;

    imm_decode_stage #(.XLEN(32), .SKID(1)) dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inst(a_out_inst), .out_pc(a_out_pc),
        .out_fmt(a_out_fmt), .out_imm(a_out_imm), .out_target(a_out_target), .out_illegal(a_out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .SKID(0)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst), .out_pc(b_out_pc),
        .out_fmt(b_out_fmt), .out_imm(b_out_imm), .out_target(b_out_target), .out_illegal(b_out_illegal)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
    } vec32_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } vec64_t;

    // fmt: R=0 I=1 S=2 B=3 U=4 J=5 Z=6
    localparam vec32_t V32 [13] = '{
        '{32'hFFF00093, 32'h00000000, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0}, // addi x1,x0,-1
        '{32'hFE000EE3, 32'h00000100, 3'd3, 32'hFFFFFFFC, 32'h000000FC, 1'b0}, // beq -4
        '{32'h3002D073, 32'h00000000, 3'd6, 32'h00005300, 32'h00005300, 1'b0}, // csrrwi
        '{32'h0000007F, 32'h00000040, 3'd0, 32'h00000000, 32'h00000040, 1'b1}, // bad opcode
        '{32'h002081B3, 32'h00000008, 3'd0, 32'h00000000, 32'h00000008, 1'b0}, // add
        '{32'hFE552FA3, 32'h00000010, 3'd2, 32'hFFFFFFFF, 32'h0000000F, 1'b0}, // sw -1
        '{32'h0200006F, 32'hFFFFFFF0, 3'd5, 32'h00000020, 32'h00000010, 1'b0}, // jal +32, wraps
        '{32'h800002B7, 32'h00000004, 3'd4, 32'h80000000, 32'h80000004, 1'b0}, // lui
        '{32'h00001297, 32'h00000100, 3'd4, 32'h00001000, 32'h00001100, 1'b0}, // auipc
        '{32'h30029073, 32'h00000000, 3'd1, 32'h00000300, 32'h00000300, 1'b0}, // csrrw -> I
        '{32'h0010009B, 32'h00000020, 3'd0, 32'h00000000, 32'h00000020, 1'b1}, // addiw on RV32
        '{32'h002080BB, 32'h00000024, 3'd0, 32'h00000000, 32'h00000024, 1'b1}, // addw on RV32
        '{32'h0000000F, 32'h00000030, 3'd1, 32'h00000000, 32'h00000030, 1'b0}  // fence
    };

    localparam vec64_t V64 [9] = '{
        '{32'h123452B7, 64'h0, 3'd4, 64'h0000000012345000, 64'h0000000012345000, 1'b0},
        '{32'h800002B7, 64'h0, 3'd4, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0},
        '{32'hFFF00093, 64'h0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0},
        '{32'h3002D073, 64'h1000, 3'd6, 64'h0000000000005300, 64'h0000000000006300, 1'b0},
        '{32'h0010009B, 64'h0, 3'd1, 64'h0000000000000001, 64'h0000000000000001, 1'b0},
        '{32'h002080BB, 64'h0, 3'd0, 64'h0, 64'h0, 1'b0},
        '{32'h0200006F, 64'hFFFFFFFFFFFFFFF0, 3'd5, 64'h20, 64'h10, 1'b0},
        '{32'hFE000EE3, 64'h100, 3'd3, 64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 1'b0},
        '{32'h0000007F, 64'h8, 3'd0, 64'h0, 64'h8, 1'b1}
    };

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_inst !== 32'h0 || a_out_pc !== 32'h0 || a_out_imm !== 32'h0
            || a_out_target !== 32'h0 || a_out_fmt !== 3'd0 || a_out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b inst=%h pc=%h imm=%h tgt=%h fmt=%0d ill=%b, expected all zero",
                     a_out_valid, a_out_inst, a_out_pc, a_out_imm, a_out_target, a_out_fmt, a_out_illegal);
        end
        n_tests++;
        if (b_out_valid !== 1'b0 || b_out_imm !== 64'h0 || b_out_target !== 64'h0 || b_out_fmt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b imm=%h tgt=%h fmt=%0d, expected all zero",
                     b_out_valid, b_out_imm, b_out_target, b_out_fmt);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got a=%b b=%b, expected 1 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_formats32();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 13; i++) begin
            a_in_valid = 1'b1;
            a_in_inst  = V32[i].inst;
            a_in_pc    = V32[i].pc;
            @(posedge clk); #1;
            a_in_valid = 1'b0;
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_inst !== V32[i].inst || a_out_fmt !== V32[i].fmt
                || a_out_imm !== V32[i].imm || a_out_target !== V32[i].tgt || a_out_illegal !== V32[i].ill) begin
                n_fail++;
                $display("FAIL fmt32[%0d]: got v=%b inst=%h fmt=%0d imm=%h tgt=%h ill=%b, expected v=1 inst=%h fmt=%0d imm=%h tgt=%h ill=%b",
                         i, a_out_valid, a_out_inst, a_out_fmt, a_out_imm, a_out_target, a_out_illegal,
                         V32[i].inst, V32[i].fmt, V32[i].imm, V32[i].tgt, V32[i].ill);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fmt32_drain: got out_valid=%b, expected 0", a_out_valid);
        end
    endtask

    task automatic test_formats64();
        b_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b_in_valid = 1'b1;
            b_in_inst  = V64[i].inst;
            b_in_pc    = V64[i].pc;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            n_tests++;
            if (b_out_valid !== 1'b1 || b_out_pc !== V64[i].pc || b_out_fmt !== V64[i].fmt
                || b_out_imm !== V64[i].imm || b_out_target !== V64[i].tgt || b_out_illegal !== V64[i].ill) begin
                n_fail++;
                $display("FAIL fmt64[%0d]: got v=%b pc=%h fmt=%0d imm=%h tgt=%h ill=%b, expected v=1 pc=%h fmt=%0d imm=%h tgt=%h ill=%b",
                         i, b_out_valid, b_out_pc, b_out_fmt, b_out_imm, b_out_target, b_out_illegal,
                         V64[i].pc, V64[i].fmt, V64[i].imm, V64[i].tgt, V64[i].ill);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_skid_fill();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_inst   = 32'h00100093; a_in_pc = 32'h1000;   // A
        @(posedge clk); #1;
        n_tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_inst !== 32'h00100093) begin
            n_fail++;
            $display("FAIL skid_after_a: got rdy=%b v=%b inst=%h, expected 1 1 00100093", a_in_ready, a_out_valid, a_out_inst);
        end
        a_in_inst = 32'h00200113; a_in_pc = 32'h1004;     // B
        @(posedge clk); #1;
        n_tests++;
        if (a_in_ready !== 1'b0 || a_out_inst !== 32'h00100093) begin
            n_fail++;
            $display("FAIL skid_after_b: got rdy=%b inst=%h, expected 0 00100093", a_in_ready, a_out_inst);
        end
        a_in_inst = 32'h00300193; a_in_pc = 32'h1008;     // C
        @(posedge clk); #1;
        n_tests++;
        if (a_in_ready !== 1'b0 || a_out_inst !== 32'h00100093 || a_out_pc !== 32'h1000 || a_out_imm !== 32'h1) begin
            n_fail++;
            $display("FAIL skid_hold: got rdy=%b inst=%h pc=%h imm=%h, expected 0 00100093 1000 1",
                     a_in_ready, a_out_inst, a_out_pc, a_out_imm);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_inst !== 32'h00200113 || a_out_pc !== 32'h1004 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_deliver_b: got v=%b inst=%h pc=%h rdy=%b, expected 1 00200113 1004 1",
                     a_out_valid, a_out_inst, a_out_pc, a_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_inst !== 32'h00300193 || a_out_pc !== 32'h1008) begin
            n_fail++;
            $display("FAIL skid_deliver_c: got v=%b inst=%h pc=%h, expected 1 00300193 1008",
                     a_out_valid, a_out_inst, a_out_pc);
        end
        @(posedge clk); #1;
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_empty: got out_valid=%b, expected 0", a_out_valid);
        end
    endtask

    task automatic test_flush();
        // fill to TWO
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_inst   = 32'h00100093; a_in_pc = 32'h2000;
        @(posedge clk); #1;
        a_in_inst   = 32'h00200113; a_in_pc = 32'h2004;
        @(posedge clk); #1;
        a_in_inst   = 32'h00400213; a_in_pc = 32'h2008;
        a_flush     = 1'b1;
        @(posedge clk); #1;
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_two: got v=%b rdy=%b, expected 0 1", a_out_valid, a_in_ready);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_lost: got out_valid=%b, expected 0", a_out_valid);
        end
        // flush beats a simultaneous accept in ONE
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_inst   = 32'h00500293; a_in_pc = 32'h3000;
        @(posedge clk); #1;
        a_in_inst   = 32'h00600313; a_in_pc = 32'h3004;
        a_flush     = 1'b1;
        @(posedge clk); #1;
        a_flush     = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_one: got v=%b rdy=%b, expected 0 1", a_out_valid, a_in_ready);
        end
        a_in_inst = 32'h00700393; a_in_pc = 32'h3008;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_inst !== 32'h00700393 || a_out_pc !== 32'h3008) begin
            n_fail++;
            $display("FAIL flush_next: got v=%b inst=%h pc=%h, expected 1 00700393 3008", a_out_valid, a_out_inst, a_out_pc);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_skid0();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_inst   = 32'hFFF00093; b_in_pc = 64'h40;
        @(posedge clk); #1;
        n_tests++;
        if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid0_stall_ready: got rdy=%b v=%b, expected 0 1", b_in_ready, b_out_valid);
        end
        b_in_inst = 32'h00100093; b_in_pc = 64'h44;
        @(posedge clk); #1;
        n_tests++;
        if (b_out_pc !== 64'h40 || b_out_imm !== 64'hFFFFFFFFFFFFFFFF || b_out_target !== 64'h3F) begin
            n_fail++;
            $display("FAIL skid0_hold: got pc=%h imm=%h tgt=%h, expected 40 ffffffffffffffff 3f", b_out_pc, b_out_imm, b_out_target);
        end
        b_out_ready = 1'b1;
        #1;
        n_tests++;
        if (b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid0_comb_ready: got %b, expected 1", b_in_ready);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_pc !== 64'h44 || b_out_imm !== 64'h1 || b_out_target !== 64'h45) begin
            n_fail++;
            $display("FAIL skid0_next: got v=%b pc=%h imm=%h tgt=%h, expected 1 44 1 45", b_out_valid, b_out_pc, b_out_imm, b_out_target);
        end
        @(posedge clk); #1;
        n_tests++;
        if (b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skid0_empty: got out_valid=%b, expected 0", b_out_valid);
        end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_inst   = 32'hFFF00093; a_in_pc = 32'h500;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_inst   = 32'h123452B7; b_in_pc = 64'h600;
        @(posedge clk); #1;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_target !== 32'h4FF) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got v=%b tgt=%h, expected 1 4ff", a_out_valid, a_out_target);
        end
        @(posedge clk); #1;   // A now holds two entries
        reset = 1'b1;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_inst !== 32'h0 || a_out_pc !== 32'h0 || a_out_imm !== 32'h0
            || a_out_target !== 32'h0 || a_out_fmt !== 3'd0 || a_out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_a: got v=%b inst=%h pc=%h imm=%h tgt=%h fmt=%0d ill=%b, expected all zero",
                     a_out_valid, a_out_inst, a_out_pc, a_out_imm, a_out_target, a_out_fmt, a_out_illegal);
        end
        n_tests++;
        if (b_out_valid !== 1'b0 || b_out_pc !== 64'h0 || b_out_imm !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_mid_b: got v=%b pc=%h imm=%h, expected 0 0 0", b_out_valid, b_out_pc, b_out_imm);
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got rdy=%b v=%b, expected 1 0", a_in_ready, a_out_valid);
        end
    endtask

    initial begin
        reset = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_inst = 32'h0; a_in_pc = 32'h0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_inst = 32'h0; b_in_pc = 64'h0;
        #1;
        test_reset();
        test_formats32();
        test_formats64();
        test_skid_fill();
        test_flush();
        test_skid0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Registered, parametrised immediate-decode pipeline stage sitting between fetch and the register-read/execute stage.
- Classifies each 32-bit RV instruction into its immediate format.
- Produces the XLEN-wide sign- or zero-extended immediate and the PC-relative branch/jump target.
- Valid/ready handshake on both sides; optional skid buffer sustains full throughput under a registered in_ready.
- Generalises the existing I/S/B/U/J/Z immediate helpers to XLEN 32/64 and adds flush, illegal-opcode flagging and target computation.

Parameters:
XLEN, 32, datapath width for imm/pc/target; legal values 32 or 64 (elaboration error otherwise).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_inst  input  32  raw instruction word
in_pc  input  XLEN  instruction address
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts this cycle
out_inst  output  32  instruction passthrough
out_pc  output  XLEN  PC passthrough
out_fmt  output  3  imm_fmt_t: R=0, I=1, S=2, B=3, U=4, J=5, Z=6
out_imm  output  XLEN  extended immediate (0 for R)
out_target  output  XLEN  out_pc + out_imm, mod 2^XLEN (valid for B/J; computed for all)
out_illegal  output  1  opcode[6:0] not in supported set

Behaviour:
- Reset (async assert): out_valid=0; out_inst/out_pc/out_imm/out_target=0; out_fmt=R; out_illegal=0; skid entry empty. in_ready=1 once reset deasserts (SKID=1: the registered in_ready resets to 1).
- Accept when in_valid && in_ready. Data appears at the outputs on the next cycle: latency 1.
- Output transfer when out_valid && out_ready. Outputs hold stable while out_valid && !out_ready.
- Format decode on opcode[6:0]:
  - 0110111/0010111 -> U.
  - 1101111 -> J.
  - 1100111/0000011/0010011/0001111 -> I; 0011011 also I, but only when XLEN=64.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1110011 with funct3[2]=1 -> Z; funct3[2]=0 -> I.
  - 0110011, and 0111011 when XLEN=64 -> R.
  - Anything else -> R with out_illegal=1.
- Extension rules:
  - I/S/B/U/J: sign-extend from inst[31] to XLEN.
  - Z: zero-extend {inst[19:15], inst[31:20]} (17 bits).
  - U at XLEN=64 sign-extends bit 31.
- Target: XLEN-bit add, wraps, no overflow flag. The decode and the adder sit before the output register, so out_target is registered.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - The output register loads on accept.
- SKID=1:
  - States EMPTY (out_valid=0), ONE (output reg full), TWO (output + skid full).
  - EMPTY: accept -> ONE.
  - ONE: accept && !transfer -> TWO; transfer && !accept -> EMPTY; accept && transfer -> ONE (new data loads).
  - TWO: transfer -> ONE (skid moves to output, same cycle); in_ready=0.
  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
  - Order is strictly FIFO. No entry is dropped or duplicated.
- flush:
  - Next cycle out_valid=0, state EMPTY, in_ready=1.
  - flush has priority over a simultaneous accept; that instruction is discarded.
  - A transfer in the flush cycle still completes, because downstream sampled it.
- Reset mid-operation: all entries are discarded immediately, asynchronously.

Decomposition:
- Shared package imm_pkg:
  - imm_fmt_t enum.
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OPIMM, OPC_OPIMM32, OPC_OP, OPC_OP32, OPC_FENCE, OPC_SYSTEM).
  - The existing immediate helpers are extended to return a raw field; widening to XLEN is done in the module.
- Sub-module imm_extract: purely combinational inst -> fmt/imm/illegal, parametrised by XLEN. The stage instantiates it once before the register.

Test Plan:
- XLEN=32, in_inst=0xFFF00093 (addi x1,x0,-1), pc=0 -> next cycle out_fmt=I, out_imm=0xFFFFFFFF, out_illegal=0.
- in_inst=0xFE000EE3 (beq x0,x0,-4), pc=0x100 -> out_fmt=B, out_imm=0xFFFFFFFC, out_target=0x000000FC.
- XLEN=64: 0x123452B7 -> out_imm=0x0000000012345000; 0x800002B7 -> out_imm=0xFFFFFFFF80000000, fmt U.
- 0x3002D073 (csrrwi x0,0x300,5) -> fmt Z, out_imm=0x5300 zero-extended; 0x0000007F -> out_illegal=1, fmt R, imm 0.
- SKID=1, out_ready=0, in_valid=1 with insts A,B,C -> A,B accepted, in_ready=0 from the cycle after B is accepted. Then raise out_ready -> A, B, C delivered in order, one per cycle, no bubble.
- State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle input is lost. Separately, reset asserted mid-stream -> outputs are zero immediately.
